// File: rtl/display_pkg.sv
// +------------------------------------------------------------------+
// | display_pkg : shared constants, FSM state type and helpers for   |
// |               the 4-digit 7-segment scan controller              |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

package display_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [13:0] MAX_VAL    = 14'd9999;
  localparam int          DP_DIGIT   = 2;

  // Active-low segment patterns, bit 0 = segment a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_DONE = ST_DONE
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: adjust then shift
  function automatic logic [29:0] dabble_step(input logic [29:0] sr);
    logic [29:0] t;
    t = sr;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (t[14+4*n +: 4] >= 4'd5)
        t[14+4*n +: 4] = t[14+4*n +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +------------------------------------------------------------------+
// | bin2bcd_seq : iterative 14-bit binary to 4-digit BCD converter,  |
// |               one double-dabble shift per clock                  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_e r_state;
  logic [3:0]  r_iter;
  logic [29:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= 4'd0;
      r_sr    <= 30'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr    <= {16'd0, bin};
            r_iter  <= 4'd0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_sr   <= dabble_step(r_sr);
          r_iter <= r_iter + 4'd1;
          if (r_iter == 4'd13)
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign bcd  = r_sr[29:14];

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// +------------------------------------------------------------------+
// | display_scan_ctrl : loads a binary value, converts it to BCD and |
// |   multiplexes four digits onto shared segment/anode pins.        |
// |   Optional: `LEADING_ZERO_BLANK_EN blanks leading zero digits.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] value,
  input  logic        dec_en,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic             w_busy;
  logic             w_done;
  logic [15:0]      w_bcd;
  logic             w_accept;
  logic [13:0]      w_clamped;
  logic [3:0]       w_cur_digit;
  logic             w_blank;

  logic [3:0]       r_digit [NUM_DIGITS];
  logic             r_dec;
  logic             r_dec_pend;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_scan_idx;

  assign w_accept  = load & ~w_busy;
  assign w_clamped = (value > MAX_VAL) ? MAX_VAL : value;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .bin   (w_clamped),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign busy = w_busy;
  assign ovf  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_dec_pend <= 1'b0;
    end else if (w_accept) begin
      r_ovf      <= (value > MAX_VAL);
      r_dec_pend <= dec_en;
    end
  end

  // Digits and dp flag commit together so the scan never sees a torn value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_DIGITS; n++)
        r_digit[n] <= 4'd0;
      r_dec <= 1'b0;
    end else if (w_done) begin
      for (int n = 0; n < NUM_DIGITS; n++)
        r_digit[n] <= w_bcd[4*n +: 4];
      r_dec <= r_dec_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_scan_idx <= 2'd0;
    end else if (r_div == C_DIV_LAST) begin
      r_div      <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_cur_digit = r_digit[r_scan_idx];

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] w_zero;
  logic [3:0] w_lead_zero;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_zero
    assign w_zero[g] = (r_digit[g] == 4'd0);
  end

  // A digit is a leading zero when it and every digit above it are zero
  assign w_lead_zero = {w_zero[3],
                        w_zero[3] & w_zero[2],
                        w_zero[3] & w_zero[2] & w_zero[1],
                        w_zero[3] & w_zero[2] & w_zero[1] & w_zero[0]};

  assign w_blank = w_lead_zero[r_scan_idx] && (r_scan_idx != 2'd0) &&
                   !(r_dec && (r_scan_idx <= 2'(DP_DIGIT)));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_scan_idx);
      seg <= w_blank ? SEG_BLANK : seg_decode(w_cur_digit);
      dp  <= ~(r_dec && (r_scan_idx == 2'(DP_DIGIT)));
    end
  end

endmodule

`default_nettype wire
